// File: rtl/seg7_scan_decoder.sv
// Reads back a multiplexed active-low 7-segment bus: synchronizes pins, qualifies stable
// digit patterns, decodes them to hex and emits one change event per digit on a valid/ready stream.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int DIG_W         = 2,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [NUM_DIGITS-1:0] dig_sel_n,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIG_W-1:0]      out_digit,
  output logic [3:0]            out_nibble,
  output logic [6:0]            out_seg,
  output logic                  out_blank,
  output logic                  out_invalid
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]            r_seg_m, r_seg_s, r_p_seg;
  logic [NUM_DIGITS-1:0] r_sel_m, r_sel_s, r_p_sel;
  logic [CNT_W-1:0]      r_cnt;
  logic [6:0]            r_last [NUM_DIGITS];

  logic             w_onehot, w_same, w_qual, w_free, w_emit;
  logic [DIG_W-1:0] w_idx;
  logic [6:0]       w_last;
  logic [3:0]       w_dec_nibble;
  logic             w_dec_blank, w_dec_invalid;

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!r_sel_s[i]) w_idx = DIG_W'(i);
    end
  end

  assign w_onehot = ($countones(~r_sel_s) == 1);
  assign w_same   = (r_seg_s == r_p_seg) && (r_sel_s == r_p_sel);
  assign w_qual   = w_onehot && w_same && (r_cnt == CNT_MAX);
  assign w_last   = r_last[w_idx];
  assign w_free   = !out_valid || out_ready;
  // Held while blocked: cnt stays saturated, so emission fires as soon as the slot frees.
  assign w_emit   = w_qual && (r_seg_s != w_last) && w_free;

  always_comb begin
    w_dec_nibble  = 4'd0;
    w_dec_blank   = 1'b0;
    w_dec_invalid = 1'b0;
    case (r_seg_s)
      7'b1000000: w_dec_nibble = 4'h0;
      7'b1111001: w_dec_nibble = 4'h1;
      7'b0100100: w_dec_nibble = 4'h2;
      7'b0110000: w_dec_nibble = 4'h3;
      7'b0011001: w_dec_nibble = 4'h4;
      7'b0010010: w_dec_nibble = 4'h5;
      7'b0000010: w_dec_nibble = 4'h6;
      7'b1111000: w_dec_nibble = 4'h7;
      7'b0000000: w_dec_nibble = 4'h8;
      7'b0010000: w_dec_nibble = 4'h9;
      7'b0001000: w_dec_nibble = 4'hA;
      7'b0000011: w_dec_nibble = 4'hB;
      7'b1000110: w_dec_nibble = 4'hC;
      7'b0100001: w_dec_nibble = 4'hD;
      7'b0000110: w_dec_nibble = 4'hE;
      7'b0001110: w_dec_nibble = 4'hF;
      7'b1111111: w_dec_blank  = 1'b1;
      default:    w_dec_invalid = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg_m     <= '1;
      r_seg_s     <= '1;
      r_sel_m     <= '1;
      r_sel_s     <= '1;
      r_p_seg     <= '1;
      r_p_sel     <= '1;
      r_cnt       <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) r_last[i] <= '1;
      out_valid   <= 1'b0;
      out_digit   <= '0;
      out_nibble  <= 4'd0;
      out_seg     <= 7'h7F;
      out_blank   <= 1'b1;
      out_invalid <= 1'b0;
    end else begin
      r_seg_m <= seg_in;
      r_seg_s <= r_seg_m;
      r_sel_m <= dig_sel_n;
      r_sel_s <= r_sel_m;

      if (!w_onehot || !w_same) begin
        r_p_seg <= r_seg_s;
        r_p_sel <= r_sel_s;
        r_cnt   <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_emit) begin
        out_valid     <= 1'b1;
        out_digit     <= w_idx;
        out_nibble    <= w_dec_nibble;
        out_seg       <= r_seg_s;
        out_blank     <= w_dec_blank;
        out_invalid   <= w_dec_invalid;
        r_last[w_idx] <= r_seg_s;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed scenarios plus randomized scan traffic, checked every cycle against a run-length reference model.
module tb_seg7_scan_decoder;

  localparam int STABLE = 16;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg_in;
  logic [3:0] dig_sel_n;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_digit;
  logic [3:0] out_nibble;
  logic [6:0] out_seg;
  logic       out_blank;
  logic       out_invalid;

  seg7_scan_decoder #(.NUM_DIGITS(4), .DIG_W(2), .STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_sel_n(dig_sel_n),
    .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
    .out_nibble(out_nibble), .out_seg(out_seg), .out_blank(out_blank),
    .out_invalid(out_invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int checks = 0;
  int errors = 0;
  int cycle_no = 0;
  int edge_no = 0;
  int first_vld_edge = 0;
  int first_nibble = 0;
  int first_digit = 0;
  int vld_cycles = 0;
  int xfers = 0;

  // Reference state: pin history since reset with run lengths, emitted table, output slot
  logic [10:0] q_pin [$];
  int          q_run [$];
  logic [6:0]  m_last [4];
  logic        m_valid;
  logic [14:0] m_data;

  function automatic int onehot_idx(input logic [3:0] sel);
    int n = 0;
    int idx = -1;
    for (int k = 0; k < 4; k++) begin
      if (!sel[k]) begin
        n++;
        idx = k;
      end
    end
    return (n == 1) ? idx : -1;
  endfunction

  // {blank, invalid, nibble}
  function automatic logic [5:0] ref_decode(input logic [6:0] s);
    if (s == 7'h7F) return 6'b10_0000;
    for (int k = 0; k < 16; k++) begin
      if (glyph[k] == s) return {2'b00, 4'(k)};
    end
    return 6'b01_0000;
  endfunction

  task automatic model_step(input logic [6:0] seg, input logic [3:0] sel,
                            input logic rdy, input logic rstn);
    logic        qual;
    logic [10:0] p;
    int          idx;
    int          run;
    logic [5:0]  dec;
    if (!rstn) begin
      m_valid = 1'b0;
      m_data  = {2'd0, 4'd0, 7'h7F, 1'b1, 1'b0};
      for (int k = 0; k < 4; k++) m_last[k] = 7'h7F;
      q_pin.delete();
      q_run.delete();
      return;
    end
    qual = 1'b0;
    idx  = -1;
    p    = '1;
    // The decoder sees pins two edges late and needs STABLE+1 identical samples of them.
    if (q_pin.size() >= 2) begin
      p    = q_pin[q_pin.size()-2];
      run  = q_run[q_run.size()-2];
      idx  = onehot_idx(p[10:7]);
      qual = (idx >= 0) && (run >= STABLE + 1);
    end
    if (qual && (p[6:0] != m_last[idx]) && (!m_valid || rdy)) begin
      dec         = ref_decode(p[6:0]);
      m_valid     = 1'b1;
      m_data      = {2'(idx), dec[3:0], p[6:0], dec[5], dec[4]};
      m_last[idx] = p[6:0];
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (q_pin.size() > 0 && q_pin[q_pin.size()-1] == {sel, seg})
      run = q_run[q_run.size()-1] + 1;
    else
      run = 1;
    q_pin.push_back({sel, seg});
    q_run.push_back(run);
    if (q_pin.size() > 4) begin
      void'(q_pin.pop_front());
      void'(q_run.pop_front());
    end
  endtask

  task automatic tick(input logic [6:0] seg, input logic [3:0] sel,
                      input logic rdy, input logic rstn);
    seg_in    = seg;
    dig_sel_n = sel;
    out_ready = rdy;
    rst_n     = rstn;
    if (rstn && out_valid === 1'b1 && rdy) xfers++;
    @(posedge clk);
    model_step(seg, sel, rdy, rstn);
    cycle_no++;
    if (!rstn) begin
      edge_no = 0;
      first_vld_edge = 0;
      vld_cycles = 0;
    end else begin
      edge_no++;
    end
    #1;
    checks++;
    assert (out_valid === m_valid)
      else begin
        errors++;
        $error("FAIL valid @%0d: got %0b expected %0b", cycle_no, out_valid, m_valid);
      end
    checks++;
    assert ({out_digit, out_nibble, out_seg, out_blank, out_invalid} === m_data)
      else begin
        errors++;
        $error("FAIL data @%0d: got %h expected %h", cycle_no,
               {out_digit, out_nibble, out_seg, out_blank, out_invalid}, m_data);
      end
    if (rstn && out_valid === 1'b1) begin
      vld_cycles++;
      if (first_vld_edge == 0) begin
        first_vld_edge = edge_no;
        first_nibble = int'(out_nibble);
        first_digit = int'(out_digit);
      end
    end
  endtask

  task automatic hold(input logic [6:0] seg, input logic [3:0] sel,
                      input logic rdy, input int n);
    for (int k = 0; k < n; k++) tick(seg, sel, rdy, 1'b1);
  endtask

  task automatic do_reset();
    tick(7'h7F, 4'hF, 1'b1, 1'b0);
    tick(7'h7F, 4'hF, 1'b1, 1'b0);
  endtask

  task automatic expect_eq(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp)
      else begin
        errors++;
        $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
  endtask

  initial begin
    int x0;
    int nrounds;
    logic [6:0] rseg;
    logic [3:0] rsel;
    int len;

    // Scenario 1: steady '2' on digit 0
    do_reset();
    expect_eq("reset_valid", int'(out_valid), 0);
    expect_eq("reset_seg", int'(out_seg), 'h7F);
    expect_eq("reset_blank", int'(out_blank), 1);
    hold(glyph[2], 4'b1110, 1'b1, 40);
    expect_eq("s1_first_edge", first_vld_edge, 19);
    expect_eq("s1_vld_cycles", vld_cycles, 1);
    expect_eq("s1_nibble", first_nibble, 2);
    expect_eq("s1_digit", first_digit, 0);

    // Scenario 2: two identical scan rounds
    do_reset();
    x0 = xfers;
    for (int r = 0; r < 2; r++) begin
      hold(glyph[3],  4'b1110, 1'b1, 32); hold(7'h7F, 4'hF, 1'b1, 2);
      hold(glyph[10], 4'b1101, 1'b1, 32); hold(7'h7F, 4'hF, 1'b1, 2);
      hold(glyph[11], 4'b1011, 1'b1, 32); hold(7'h7F, 4'hF, 1'b1, 2);
      hold(glyph[15], 4'b0111, 1'b1, 32); hold(7'h7F, 4'hF, 1'b1, 2);
      expect_eq(r == 0 ? "s2_round1_events" : "s2_round2_events", xfers - x0, 4);
    end

    // Scenario 3: glitch restarts qualification
    do_reset();
    hold(glyph[2], 4'b1110, 1'b1, 10);
    hold(glyph[1], 4'b1110, 1'b1, 5);
    hold(glyph[2], 4'b1110, 1'b1, 40);
    expect_eq("s3_first_edge", first_vld_edge, 34);
    expect_eq("s3_vld_cycles", vld_cycles, 1);
    expect_eq("s3_nibble", first_nibble, 2);

    // Scenario 4: backpressure for 100 cycles
    do_reset();
    x0 = xfers;
    hold(glyph[7], 4'b1101, 1'b0, 50);
    expect_eq("s4_held_valid", int'(out_valid), 1);
    hold(glyph[8], 4'b1011, 1'b0, 50);
    expect_eq("s4_frozen_digit", int'(out_digit), 1);
    expect_eq("s4_frozen_nibble", int'(out_nibble), 7);
    tick(glyph[8], 4'b1011, 1'b1, 1'b1);
    expect_eq("s4_b2b_valid", int'(out_valid), 1);
    expect_eq("s4_b2b_digit", int'(out_digit), 2);
    expect_eq("s4_b2b_nibble", int'(out_nibble), 8);
    hold(glyph[8], 4'b1011, 1'b1, 5);
    expect_eq("s4_events", xfers - x0, 2);

    // Scenario 5: invalid then blank on digit 0
    do_reset();
    hold(7'b1010101, 4'b1110, 1'b0, 25);
    expect_eq("s5_invalid", int'(out_invalid), 1);
    expect_eq("s5_inv_nibble", int'(out_nibble), 0);
    expect_eq("s5_inv_seg", int'(out_seg), 'h55);
    tick(7'b1010101, 4'b1110, 1'b1, 1'b1);
    hold(7'h7F, 4'b1110, 1'b0, 25);
    expect_eq("s5_blank_valid", int'(out_valid), 1);
    expect_eq("s5_blank", int'(out_blank), 1);
    expect_eq("s5_blank_invalid", int'(out_invalid), 0);

    // Scenario 6: reset while an event is pending
    do_reset();
    hold(glyph[5], 4'b1110, 1'b0, 25);
    expect_eq("s6_pending", int'(out_valid), 1);
    tick(glyph[5], 4'b1110, 1'b0, 1'b0);
    expect_eq("s6_reset_drop", int'(out_valid), 0);
    hold(glyph[5], 4'b1110, 1'b1, 30);
    expect_eq("s6_reemit_edge", first_vld_edge, 19);
    expect_eq("s6_reemit_nibble", first_nibble, 5);

    // Randomized scan traffic with random backpressure, glitches and resets
    nrounds = 300;
    for (int r = 0; r < nrounds; r++) begin
      case ($urandom_range(0, 9))
        7:       rseg = 7'h7F;
        8:       rseg = 7'($urandom);
        default: rseg = glyph[$urandom_range(0, 15)];
      endcase
      case ($urandom_range(0, 9))
        0:       rsel = 4'hF;
        1:       rsel = 4'($urandom);
        default: rsel = ~(4'b0001 << $urandom_range(0, 3));
      endcase
      len = $urandom_range(1, 40);
      for (int k = 0; k < len; k++)
        tick(rseg, rsel, ($urandom_range(0, 3) != 0), 1'b1);
      if ($urandom_range(0, 59) == 0) tick(rseg, rsel, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
